// File: rtl/mda_video_out.sv
// MDA/Hercules video output stage: fixed-latency re-registration, phosphor palette,
// sync polarity, and a horizontal lock detector that blanks RGB until line timing is stable.
module mda_video_out #(
    parameter int PALETTE    = 0,
    parameter bit HSYNC_POL  = 1'b1,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int LOCK_LINES = 4,
    parameter int LEN_TOL    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        video_in,
    input  logic        intensity_in,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        locked,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

    localparam logic [11:0] PAL_NORMAL = (PALETTE == 0) ? 12'hA70 :
                                         (PALETTE == 1) ? 12'h0A0 : 12'hAAA;
    localparam logic [11:0] PAL_BRIGHT = (PALETTE == 0) ? 12'hFB0 :
                                         (PALETTE == 1) ? 12'h0F0 : 12'hFFF;
    localparam logic [10:0] TOL        = 11'(LEN_TOL);
    localparam logic [7:0]  LOCK_TGT   = 8'(LOCK_LINES - 1);
    localparam logic [10:0] LINE_MAX   = 11'h7FF;
    localparam logic [9:0]  FRAME_MAX  = 10'h3FF;

    logic s1_h, s1_v, s1_vid, s1_int;
    logic s2_h, s2_v, s2_vid, s2_int;
    logic s3_h, s3_v;
    logic h_rise, v_rise;

    logic [10:0] line_cnt;
    logic        line_sat;
    logic [9:0]  frame_cnt;
    logic [9:0]  frame_inc;

    lock_state_t state, state_nxt;
    logic [10:0] ref_len, ref_len_nxt;
    logic [7:0]  match_cnt, match_cnt_nxt;
    logic [7:0]  match_inc;
    logic [10:0] line_len_nxt;
    logic [11:0] pix_rgb;

    function automatic logic len_ok(input logic [10:0] a, input logic [10:0] ref_v);
        logic [10:0] d;
        d = (a > ref_v) ? (a - ref_v) : (ref_v - a);
        return (d <= TOL);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_h   <= 1'b0;
            s1_v   <= 1'b0;
            s1_vid <= 1'b0;
            s1_int <= 1'b0;
            s2_h   <= 1'b0;
            s2_v   <= 1'b0;
            s2_vid <= 1'b0;
            s2_int <= 1'b0;
            s3_h   <= 1'b0;
            s3_v   <= 1'b0;
        end else begin
            s1_h   <= hsync_in;
            s1_v   <= vsync_in;
            s1_vid <= video_in;
            s1_int <= intensity_in;
            s2_h   <= s1_h;
            s2_v   <= s1_v;
            s2_vid <= s1_vid;
            s2_int <= s1_int;
            s3_h   <= s2_h;
            s3_v   <= s2_v;
        end
    end

    assign h_rise = s2_h & ~s3_h;
    assign v_rise = s2_v & ~s3_v;

    // line_cnt holds the number of cycles since the previous hsync rise
    assign line_sat = (line_cnt == LINE_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            line_cnt <= '0;
        end else if (h_rise) begin
            line_cnt <= 11'd1;
        end else if (!line_sat) begin
            line_cnt <= line_cnt + 11'd1;
        end
    end

    assign match_inc = match_cnt + 8'd1;

    always_comb begin
        state_nxt     = state;
        ref_len_nxt   = ref_len;
        match_cnt_nxt = match_cnt;
        line_len_nxt  = line_len;
        case (state)
            SEARCH: begin
                // A stale reference would let a partial re-acquire lock early
                if (h_rise) begin
                    state_nxt     = ACQUIRE;
                    match_cnt_nxt = '0;
                    ref_len_nxt   = '0;
                end
            end
            ACQUIRE: begin
                if (h_rise) begin
                    if (len_ok(line_cnt, ref_len)) begin
                        match_cnt_nxt = match_inc;
                        if (match_inc >= LOCK_TGT) begin
                            state_nxt    = LOCKED;
                            line_len_nxt = ref_len;
                        end
                    end else begin
                        ref_len_nxt   = line_cnt;
                        match_cnt_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if ((h_rise && !len_ok(line_cnt, line_len)) || line_sat) begin
                    state_nxt = SEARCH;
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEARCH;
            ref_len   <= '0;
            match_cnt <= '0;
            line_len  <= '0;
        end else begin
            state     <= state_nxt;
            ref_len   <= ref_len_nxt;
            match_cnt <= match_cnt_nxt;
            line_len  <= line_len_nxt;
        end
    end

    assign locked = (state == LOCKED);

    // A coincident hsync rise belongs to the frame that is ending
    assign frame_inc = (frame_cnt == FRAME_MAX) ? frame_cnt : frame_cnt + 10'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            frame_lines <= '0;
        end else if (v_rise && (state == LOCKED)) begin
            frame_lines <= h_rise ? frame_inc : frame_cnt;
            frame_cnt   <= '0;
        end else if (h_rise) begin
            frame_cnt <= frame_inc;
        end
    end

    always_comb begin
        pix_rgb = 12'h000;
        if (s2_vid) begin
            pix_rgb = s2_int ? PAL_BRIGHT : PAL_NORMAL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r         <= '0;
            g         <= '0;
            b         <= '0;
            hsync_out <= ~HSYNC_POL;
            vsync_out <= ~VSYNC_POL;
        end else begin
            r         <= locked ? pix_rgb[11:8] : 4'h0;
            g         <= locked ? pix_rgb[7:4]  : 4'h0;
            b         <= locked ? pix_rgb[3:0]  : 4'h0;
            hsync_out <= ~(s2_h ^ HSYNC_POL);
            vsync_out <= ~(s2_v ^ VSYNC_POL);
        end
    end

endmodule

// File: tb/tb_mda_video_out.sv
// Directed bench for mda_video_out: four palette instances share one stimulus stream.
module tb_mda_video_out;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic hsync_in = 1'b0;
    logic vsync_in = 1'b0;
    logic video_in = 1'b0;
    logic intensity_in = 1'b0;

    logic [3:0]  r_o [4];
    logic [3:0]  g_o [4];
    logic [3:0]  b_o [4];
    logic        hs_o [4];
    logic        vs_o [4];
    logic        lk_o [4];
    logic [10:0] ll_o [4];
    logic [9:0]  fl_o [4];

    int checks = 0;
    int failures = 0;

    int  pos = 0;
    int  cur_len = 800;
    int  hs_width = 96;
    bit  hs_en = 1'b0;
    int  frame_len = 0;
    int  line_idx = 0;
    int  vs_start = 10;

    always #5 clk = ~clk;

    for (genvar p = 0; p < 4; p++) begin : g_dut
        mda_video_out #(.PALETTE(p)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .hsync_in     (hsync_in),
            .vsync_in     (vsync_in),
            .video_in     (video_in),
            .intensity_in (intensity_in),
            .r            (r_o[p]),
            .g            (g_o[p]),
            .b            (b_o[p]),
            .hsync_out    (hs_o[p]),
            .vsync_out    (vs_o[p]),
            .locked       (lk_o[p]),
            .line_len     (ll_o[p]),
            .frame_lines  (fl_o[p])
        );
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one pixel of the synthetic timing, then advance past the next rising edge
    task automatic step();
        hsync_in = hs_en && (pos < hs_width);
        vsync_in = (frame_len != 0) && (line_idx == 0) && (pos >= vs_start) && (pos < vs_start + 8);
        @(posedge clk);
        #1;
        if (pos + 1 >= cur_len) begin
            pos = 0;
            if (frame_len != 0) line_idx = (line_idx + 1 >= frame_len) ? 0 : line_idx + 1;
        end else begin
            pos++;
        end
    endtask

    task automatic finish_line();
        do step(); while (pos != 0);
    endtask

    task automatic run_until(input int ln, input int p);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(line_idx == ln && pos == p) && n < 20000);
        check("run_until_bound", 32'(n < 20000), 32'd1);
    endtask

    function automatic logic [11:0] exp_rgb(input int p, input bit v, input bit i);
        if (!v) return 12'h000;
        case (p)
            0:       return i ? 12'hFB0 : 12'hA70;
            1:       return i ? 12'h0F0 : 12'h0A0;
            default: return i ? 12'hFFF : 12'hAAA;
        endcase
    endfunction

    function automatic logic [11:0] rgb(input int p);
        return {r_o[p], g_o[p], b_o[p]};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        step();
        step();
        check("rst_rgb", 32'(rgb(0)), 32'h000);
        check("rst_hsync_out", 32'(hs_o[0]), 32'd0);
        check("rst_vsync_out", 32'(vs_o[0]), 32'd1);
        check("rst_locked", 32'(lk_o[0]), 32'd0);
        check("rst_line_len", 32'(ll_o[0]), 32'd0);
        check("rst_frame_lines", 32'(fl_o[0]), 32'd0);
        reset = 1'b0;
        pos = 0;
        hs_en = 1'b1;

        // Lock on 800-clock lines: arm, then four line-completing edges
        repeat (4 * 800) step();
        step();
        step();
        check("lock_pre_edge", 32'(lk_o[0]), 32'd0);
        step();
        check("lock_after_4th", 32'(lk_o[0]), 32'd1);
        check("lock_line_len", 32'(ll_o[0]), 32'd800);

        // Pixel latency of exactly three clocks
        video_in = 1'b1;
        intensity_in = 1'b0;
        step();
        step();
        check("pix_before_latency", 32'(rgb(0)), 32'h000);
        step();
        check("pix_amber_normal", 32'(rgb(0)), 32'hA70);

        // Palette sweep across every instance and video/intensity pair
        for (int k = 0; k < 4; k++) begin
            video_in = k[1];
            intensity_in = k[0];
            repeat (3) step();
            for (int p = 0; p < 4; p++) begin
                check($sformatf("pal%0d_vi%0d", p, k), 32'(rgb(p)), 32'(exp_rgb(p, k[1], k[0])));
            end
        end

        // Tolerance: 801 keeps lock, 803 drops it
        video_in = 1'b1;
        intensity_in = 1'b0;
        cur_len = 801;
        finish_line();
        cur_len = 800;
        repeat (3) step();
        check("tol_801_locked", 32'(lk_o[0]), 32'd1);
        cur_len = 803;
        finish_line();
        cur_len = 800;
        step();
        step();
        check("tol_803_pre_locked", 32'(lk_o[0]), 32'd1);
        check("tol_803_pre_rgb", 32'(rgb(0)), 32'hA70);
        step();
        check("tol_803_unlocked", 32'(lk_o[0]), 32'd0);
        step();
        check("tol_803_blank", 32'(rgb(0)), 32'h000);
        check("tol_hsync_high", 32'(hs_o[0]), 32'd1);
        do step(); while (pos != 150);
        check("tol_hsync_low", 32'(hs_o[0]), 32'd0);

        // Relock, then remove hsync and watch the counter saturate
        finish_line();
        repeat (4 * 800 + 3) step();
        check("relock_locked", 32'(lk_o[0]), 32'd1);
        finish_line();
        step();
        hs_en = 1'b0;
        repeat (2048) step();
        check("sat_still_locked", 32'(lk_o[0]), 32'd1);
        step();
        check("sat_unlocked", 32'(lk_o[0]), 32'd0);

        finish_line();
        hs_en = 1'b1;
        repeat (4 * 800 + 3) step();
        check("restore_locked", 32'(lk_o[0]), 32'd1);
        check("restore_line_len", 32'(ll_o[0]), 32'd800);

        // Shorter lines keep the frame test small
        cur_len = 24;
        hs_width = 8;
        repeat (10 * 24) step();
        check("short_locked", 32'(lk_o[0]), 32'd1);
        check("short_line_len", 32'(ll_o[0]), 32'd24);

        frame_len = 370;
        line_idx = 1;
        vs_start = 10;
        run_until(0, 20);
        run_until(0, 20);
        check("frame_370", 32'(fl_o[0]), 32'd370);
        vs_start = 0;
        run_until(0, 20);
        check("frame_coincident", 32'(fl_o[0]), 32'd370);
        run_until(0, 20);
        check("frame_after_coincident", 32'(fl_o[0]), 32'd370);

        // Reset mid-line while hsync and vsync are both active
        run_until(0, 5);
        reset = 1'b1;
        step();
        check("mid_rst_rgb", 32'(rgb(0)), 32'h000);
        check("mid_rst_hsync_out", 32'(hs_o[0]), 32'd0);
        check("mid_rst_vsync_out", 32'(vs_o[0]), 32'd1);
        check("mid_rst_locked", 32'(lk_o[0]), 32'd0);
        check("mid_rst_line_len", 32'(ll_o[0]), 32'd0);
        check("mid_rst_frame_lines", 32'(fl_o[0]), 32'd0);
        step();
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
